// File: rtl/tank_move_ctrl.sv
// Per-tank motion and life controller: sub-pixel stepping from a one-hot key vector,
// playfield clamping, single-step collision rollback, and a death/respawn/shield sequence.
module tank_move_ctrl #(
    parameter int INITIAL_X      = 280,
    parameter int INITIAL_Y      = 185,
    parameter int INITIAL_DIR    = 1,
    parameter int FRAC_BITS      = 6,
    parameter int SPEED          = 20,
    parameter int BOOST_SPEED    = 40,
    parameter int COORD_W        = 11,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 640,
    parameter int Y_MIN          = 0,
    parameter int Y_MAX          = 480,
    parameter int OBJ_SIZE       = 32,
    parameter int N_COLL         = 3,
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 60,
    parameter int SHIELD_FRAMES  = 90
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startOfFrame,
    input  logic [3:0]                 inputKeyPressed,
    input  logic                       boost,
    input  logic [N_COLL-1:0]          collision,
    input  logic                       missileHit,
    output logic [COORD_W-1:0]         topLeftX,
    output logic [COORD_W-1:0]         topLeftY,
    output logic [1:0]                 tankDir,
    output logic                       alive,
    output logic                       visible,
    output logic                       shielded,
    output logic [$clog2(LIVES+1)-1:0] livesLeft,
    output logic                       gameOver
);

    localparam int W       = COORD_W + FRAC_BITS + 1;
    localparam int LW      = $clog2(LIVES + 1);
    localparam int CNT_MAX = (RESPAWN_FRAMES > SHIELD_FRAMES) ? RESPAWN_FRAMES : SHIELD_FRAMES;
    localparam int CW_RAW  = $clog2(CNT_MAX + 1);
    // The shield blink reads counter bit 2, so the counter is never narrower than 3 bits.
    localparam int CW      = (CW_RAW < 3) ? 3 : CW_RAW;

    typedef logic signed [W-1:0] coord_t;

    localparam coord_t ZERO_FP   = {W{1'b0}};
    localparam coord_t X_LO      = coord_t'(X_MIN * (2 ** FRAC_BITS));
    localparam coord_t X_HI      = coord_t'((X_MAX - OBJ_SIZE) * (2 ** FRAC_BITS));
    localparam coord_t Y_LO      = coord_t'(Y_MIN * (2 ** FRAC_BITS));
    localparam coord_t Y_HI      = coord_t'((Y_MAX - OBJ_SIZE) * (2 ** FRAC_BITS));
    localparam coord_t INIT_X_FP = coord_t'(INITIAL_X * (2 ** FRAC_BITS));
    localparam coord_t INIT_Y_FP = coord_t'(INITIAL_Y * (2 ** FRAC_BITS));
    localparam coord_t SPEED_FP  = coord_t'(SPEED);
    localparam coord_t BOOST_FP  = coord_t'(BOOST_SPEED);

    localparam logic [1:0]    INIT_DIR    = 2'(INITIAL_DIR);
    localparam logic [LW-1:0] LIVES_INIT  = LW'(LIVES);
    localparam logic [LW-1:0] LIVES_ONE   = LW'(1);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] RESPAWN_CNT = CW'(RESPAWN_FRAMES);
    localparam logic [CW-1:0] SHIELD_CNT  = CW'(SHIELD_FRAMES);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_SHIELD = 2'd1,
        ST_DEAD   = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    function automatic coord_t clamp(input coord_t v, input coord_t lo, input coord_t hi);
        if (v < lo) begin
            clamp = lo;
        end else if (v > hi) begin
            clamp = hi;
        end else begin
            clamp = v;
        end
    endfunction

    state_t        state_r, state_s;
    coord_t        x_r, x_s, y_r, y_s;
    coord_t        last_dx_r, last_dx_s, last_dy_r, last_dy_s;
    logic          rb_done_r, rb_done_s;
    logic [1:0]    dir_r, dir_s;
    logic [LW-1:0] lives_r, lives_s;
    logic [CW-1:0] cnt_r, cnt_s;

    coord_t        step_s, dx_s, dy_s, mv_x_s, mv_y_s;
    logic [1:0]    key_dir_s;

    // Candidate frame move: decode the key vector and clamp the stepped position.
    always_comb begin
        step_s    = boost ? BOOST_FP : SPEED_FP;
        dx_s      = ZERO_FP;
        dy_s      = ZERO_FP;
        key_dir_s = dir_r;
        case (inputKeyPressed)
            4'b0001: begin dy_s = step_s;  key_dir_s = 2'd2; end
            4'b0010: begin dy_s = -step_s; key_dir_s = 2'd0; end
            4'b0100: begin dx_s = -step_s; key_dir_s = 2'd3; end
            4'b1000: begin dx_s = step_s;  key_dir_s = 2'd1; end
            default: begin dx_s = ZERO_FP; dy_s = ZERO_FP; key_dir_s = dir_r; end
        endcase
        mv_x_s = clamp(x_r + dx_s, X_LO, X_HI);
        mv_y_s = clamp(y_r + dy_s, Y_LO, Y_HI);
    end

    // Next-state logic: missile hit beats rollback, rollback beats the frame step.
    always_comb begin
        state_s   = state_r;
        x_s       = x_r;
        y_s       = y_r;
        last_dx_s = last_dx_r;
        last_dy_s = last_dy_r;
        rb_done_s = rb_done_r;
        dir_s     = dir_r;
        lives_s   = lives_r;
        cnt_s     = cnt_r;
        case (state_r)
            ST_ALIVE, ST_SHIELD: begin
                if (missileHit && (state_r == ST_ALIVE)) begin
                    lives_s = lives_r - LIVES_ONE;
                    if (lives_r == LIVES_ONE) begin
                        state_s = ST_OVER;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_DEAD;
                        cnt_s   = RESPAWN_CNT;
                    end
                end else begin
                    if ((|collision) && !rb_done_r) begin
                        x_s       = x_r - last_dx_r;
                        y_s       = y_r - last_dy_r;
                        rb_done_s = 1'b1;
                    end else if (startOfFrame) begin
                        x_s       = mv_x_s;
                        y_s       = mv_y_s;
                        last_dx_s = mv_x_s - x_r;
                        last_dy_s = mv_y_s - y_r;
                        dir_s     = key_dir_s;
                        rb_done_s = 1'b0;
                    end else begin
                        rb_done_s = rb_done_r;
                    end
                    // The shield timer runs on frames even when a rollback pre-empts the move.
                    if (startOfFrame && (state_r == ST_SHIELD)) begin
                        if (cnt_r <= CNT_ONE) begin
                            state_s = ST_ALIVE;
                            cnt_s   = CNT_ZERO;
                        end else begin
                            cnt_s = cnt_r - CNT_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
            end
            ST_DEAD: begin
                if (startOfFrame) begin
                    if (cnt_r <= CNT_ONE) begin
                        state_s   = ST_SHIELD;
                        cnt_s     = SHIELD_CNT;
                        x_s       = INIT_X_FP;
                        y_s       = INIT_Y_FP;
                        dir_s     = INIT_DIR;
                        last_dx_s = ZERO_FP;
                        last_dy_s = ZERO_FP;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_OVER: begin
                state_s = ST_OVER;
            end
            default: begin
                state_s = ST_OVER;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_ALIVE;
            x_r       <= INIT_X_FP;
            y_r       <= INIT_Y_FP;
            last_dx_r <= ZERO_FP;
            last_dy_r <= ZERO_FP;
            rb_done_r <= 1'b0;
            dir_r     <= INIT_DIR;
            lives_r   <= LIVES_INIT;
            cnt_r     <= CNT_ZERO;
        end else begin
            state_r   <= state_s;
            x_r       <= x_s;
            y_r       <= y_s;
            last_dx_r <= last_dx_s;
            last_dy_r <= last_dy_s;
            rb_done_r <= rb_done_s;
            dir_r     <= dir_s;
            lives_r   <= lives_s;
            cnt_r     <= cnt_s;
        end
    end

    assign topLeftX  = x_r[FRAC_BITS +: COORD_W];
    assign topLeftY  = y_r[FRAC_BITS +: COORD_W];
    assign tankDir   = dir_r;
    assign livesLeft = lives_r;
    assign alive     = (state_r == ST_ALIVE) || (state_r == ST_SHIELD);
    assign shielded  = (state_r == ST_SHIELD);
    assign gameOver  = (state_r == ST_OVER);
    assign visible   = (state_r == ST_ALIVE) || ((state_r == ST_SHIELD) && cnt_r[2]);

endmodule

// File: tb/tb_tank_move_ctrl.sv
// Scoreboard bench for tank_move_ctrl: directed scenarios plus random traffic,
// checked every cycle against an integer reference model of the movement and life rules.
module tb_tank_move_ctrl;

    localparam int FB    = 6;
    localparam int IX    = 280 * 64;
    localparam int IY    = 185 * 64;
    localparam int IDIR  = 1;
    localparam int SPD   = 20;
    localparam int BSPD  = 40;
    localparam int XLO   = 0;
    localparam int XHI   = (640 - 32) * 64;
    localparam int YLO   = 0;
    localparam int YHI   = (480 - 32) * 64;
    localparam int RESP  = 60;
    localparam int SHLD  = 90;

    localparam int M_ALIVE  = 0;
    localparam int M_SHIELD = 1;
    localparam int M_DEAD   = 2;
    localparam int M_OVER   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        sof;
    logic [3:0]  keys;
    logic        boost;
    logic [2:0]  coll;
    logic        hit;
    logic [10:0] top_x;
    logic [10:0] top_y;
    logic [1:0]  dir;
    logic        alive;
    logic        visible;
    logic        shielded;
    logic [1:0]  lives;
    logic        over;

    always #5 clk = ~clk;

    tank_move_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (sof),
        .inputKeyPressed (keys),
        .boost           (boost),
        .collision       (coll),
        .missileHit      (hit),
        .topLeftX        (top_x),
        .topLeftY        (top_y),
        .tankDir         (dir),
        .alive           (alive),
        .visible         (visible),
        .shielded        (shielded),
        .livesLeft       (lives),
        .gameOver        (over)
    );

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [1:0]  dir;
        logic        alive;
        logic        visible;
        logic        shielded;
        logic [1:0]  lives;
        logic        over;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_st, m_px, m_py, m_ldx, m_ldy, m_dir, m_lives, m_cnt;
    bit m_rb;

    function automatic int sat(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.x        = 11'(m_px / 64);
        o.y        = 11'(m_py / 64);
        o.dir      = 2'(m_dir);
        o.alive    = (m_st == M_ALIVE) || (m_st == M_SHIELD);
        o.shielded = (m_st == M_SHIELD);
        o.visible  = (m_st == M_ALIVE) || ((m_st == M_SHIELD) && (((m_cnt / 4) % 2) == 1));
        o.lives    = 2'(m_lives);
        o.over     = (m_st == M_OVER);
        return o;
    endfunction

    task automatic model_step(input logic [3:0] k, input logic b, input logic [2:0] c,
                              input logic s, input logic h, input logic r);
        int sp, dx, dy, nx, ny;
        if (r) begin
            m_st = M_ALIVE; m_px = IX; m_py = IY; m_ldx = 0; m_ldy = 0;
            m_rb = 1'b0; m_dir = IDIR; m_lives = 3; m_cnt = 0;
        end else if (m_st == M_ALIVE || m_st == M_SHIELD) begin
            if (h && m_st == M_ALIVE) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_st = M_OVER;
                else begin m_st = M_DEAD; m_cnt = RESP; end
            end else begin
                if (c != 3'b000 && !m_rb) begin
                    m_px = m_px - m_ldx;
                    m_py = m_py - m_ldy;
                    m_rb = 1'b1;
                end else if (s) begin
                    sp = b ? BSPD : SPD;
                    dx = 0;
                    dy = 0;
                    if ($countones(k) == 1) begin
                        if (k[0]) begin dy = sp;  m_dir = 2; end
                        if (k[1]) begin dy = -sp; m_dir = 0; end
                        if (k[2]) begin dx = -sp; m_dir = 3; end
                        if (k[3]) begin dx = sp;  m_dir = 1; end
                    end
                    nx = sat(m_px + dx, XLO, XHI);
                    ny = sat(m_py + dy, YLO, YHI);
                    m_ldx = nx - m_px;
                    m_ldy = ny - m_py;
                    m_px = nx;
                    m_py = ny;
                    m_rb = 1'b0;
                end
                if (s && m_st == M_SHIELD) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_st = M_ALIVE;
                end
            end
        end else if (m_st == M_DEAD) begin
            if (s) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_st = M_SHIELD; m_cnt = SHLD;
                    m_px = IX; m_py = IY; m_dir = IDIR; m_ldx = 0; m_ldy = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic [3:0] k, input logic b, input logic [2:0] c,
                       input logic s, input logic h, input logic r);
        @(negedge clk);
        keys = k; boost = b; coll = c; sof = s; hit = h; reset = r;
        model_step(k, b, c, s, h, r);
        exp_q.push_back(model_obs());
    endtask

    task automatic frame(input logic [3:0] k, input logic b);
        cyc(k, b, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc(k, b, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs with the next scoreboard entry after every edge.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.x = top_x; a.y = top_y; a.dir = dir; a.alive = alive; a.visible = visible;
                a.shielded = shielded; a.lives = lives; a.over = over;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: got x=%0d y=%0d dir=%0d alive=%0b vis=%0b sh=%0b lives=%0d over=%0b expected x=%0d y=%0d dir=%0d alive=%0b vis=%0b sh=%0b lives=%0d over=%0b",
                             $time, a.x, a.y, a.dir, a.alive, a.visible, a.shielded, a.lives, a.over,
                             e.x, e.y, e.dir, e.alive, e.visible, e.shielded, e.lives, e.over);
                end
            end
        end
    end

    initial begin
        logic [3:0] rk;
        reset = 1'b0; sof = 1'b0; keys = 4'b0000; boost = 1'b0; coll = 3'b000; hit = 1'b0;

        // Reset values
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        sync();
        chk("reset_x", top_x, 280); chk("reset_y", top_y, 185); chk("reset_dir", dir, 1);
        chk("reset_alive", alive, 1); chk("reset_vis", visible, 1); chk("reset_shield", shielded, 0);
        chk("reset_lives", lives, 3); chk("reset_over", over, 0);

        // Ten normal-speed frames to the right
        repeat (10) frame(4'b1000, 1'b0);
        sync();
        chk("right10_x", top_x, 283); chk("right10_y", top_y, 185); chk("right10_dir", dir, 1);

        // One step, collision held three cycles rolls back only once
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        frame(4'b1000, 1'b0);
        repeat (3) cyc(4'b0000, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
        sync();
        chk("rollback_x", top_x, 280);
        repeat (4) frame(4'b1000, 1'b0);
        sync();
        chk("after_rollback_x", top_x, 281);

        // Ambiguous keys do nothing; single up key moves and turns
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        repeat (5) frame(4'b0101, 1'b0);
        sync();
        chk("multikey_x", top_x, 280); chk("multikey_y", top_y, 185); chk("multikey_dir", dir, 1);
        frame(4'b0010, 1'b0);
        sync();
        chk("up_dir", dir, 0); chk("up_y", top_y, 184);

        // Boost into the right wall; partial last step is what gets rolled back
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        repeat (525) frame(4'b1000, 1'b1);
        sync();
        chk("clamp_x", top_x, 608);
        cyc(4'b0000, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        sync();
        chk("clamp_rollback_x", top_x, 607);
        repeat (475) frame(4'b1000, 1'b1);
        sync();
        chk("clamp_hold_x", top_x, 608);

        // Death, respawn, shield
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        frame(4'b0010, 1'b0);
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        sync();
        chk("dead_alive", alive, 0); chk("dead_vis", visible, 0); chk("dead_lives", lives, 2);
        repeat (59) frame(4'b1000, 1'b0);
        sync();
        chk("dead59_alive", alive, 0); chk("dead59_y", top_y, 184);
        frame(4'b0000, 1'b0);
        sync();
        chk("respawn_x", top_x, 280); chk("respawn_y", top_y, 185); chk("respawn_dir", dir, 1);
        chk("respawn_shield", shielded, 1); chk("respawn_alive", alive, 1);
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        sync();
        chk("shield_hit_lives", lives, 2); chk("shield_hit_sh", shielded, 1);
        repeat (89) frame(4'b0000, 1'b0);
        sync();
        chk("shield89", shielded, 1);
        frame(4'b0000, 1'b0);
        sync();
        chk("shield_end", shielded, 0); chk("shield_end_alive", alive, 1);

        // Remaining lives to game over, which is sticky
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        repeat (150) frame(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        sync();
        chk("over_flag", over, 1); chk("over_alive", alive, 0); chk("over_vis", visible, 0);
        chk("over_lives", lives, 0);
        repeat (20) frame(4'b1000, 1'b0);
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        sync();
        chk("over_sticky", over, 1);

        // Reset while dead
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        repeat (10) frame(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        sync();
        chk("rst_dead_lives", lives, 3); chk("rst_dead_alive", alive, 1);
        chk("rst_dead_over", over, 0); chk("rst_dead_vis", visible, 1);

        // Random traffic
        repeat (4000) begin
            if ($urandom_range(3, 0) != 0) rk = 4'b0001 << $urandom_range(3, 0);
            else rk = 4'($urandom_range(15, 0));
            cyc(rk, 1'($urandom_range(1, 0)),
                ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 0)) : 3'b000,
                $urandom_range(2, 0) == 0,
                $urandom_range(149, 0) == 0,
                $urandom_range(1499, 0) == 0);
        end
        sync();
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
